// File: rtl/audio_codec_if_pkg.sv
// Shared constants, types and slot helpers for the audio codec interface.
package audio_codec_if_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int SLOT_BITS     = 32;
    localparam int FRAME_BITS    = 64;
    localparam int MCLK_DIV      = 4;

    localparam int CNT_W         = $clog2(FRAME_BITS);
    localparam int IDX_W         = $clog2(SAMPLE_W);
    localparam int POS_W         = $clog2(SLOT_BITS);
    localparam int MCLK_HALF     = MCLK_DIV / 2;
    localparam int MCLK_CNT_W    = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int LAST_SLOT     = FRAME_BITS - 1;
    localparam int ADC_LAST_SLOT = SLOT_BITS + SAMPLE_W - 1;

    typedef enum logic {
        GEN_IDLE,
        GEN_RUN
    } gen_state_t;

    // True for the slots of a channel half that carry sample bits.
    function automatic logic slot_active(input logic [CNT_W-1:0] slot);
        logic [POS_W-1:0] pos;
        pos = slot[POS_W-1:0];
        return pos < POS_W'(SAMPLE_W);
    endfunction

    // Sample bit carried by an active slot: MSB in the first slot of the channel.
    function automatic logic [IDX_W-1:0] slot_bit_index(input logic [CNT_W-1:0] slot);
        return ~slot[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// BCLK/LRCK timing generator: divides clk to the bit clock and tracks the frame slot.
module audio_clk_gen
    import audio_codec_if_pkg::*;
#(
    parameter int BCLK_HALF = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             bclk,
    output logic             lrck,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             rise,
    output logic             fall
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);

    gen_state_t       state_q, state_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             running;
    logic             toggle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= GEN_IDLE;
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '1;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // The cycle that first samples enable only arms the generator, so the
    // first bit-clock toggle lands exactly BCLK_HALF cycles after it.
    always_comb begin
        state_d   = enable ? GEN_RUN : GEN_IDLE;
        running   = (state_q == GEN_RUN) && enable;
        toggle    = running && (div_cnt_q == DIV_LAST);
        rise      = toggle && !bclk_q;
        fall      = toggle && bclk_q;
        div_cnt_d = '0;
        bclk_d    = 1'b0;
        bit_cnt_d = '1;
        if (running) begin
            div_cnt_d = toggle ? '0 : div_cnt_q + 8'd1;
            bclk_d    = bclk_q ^ toggle;
            bit_cnt_d = fall ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
        end
    end

    assign bclk    = bclk_q;
    assign bit_cnt = bit_cnt_q;
    assign lrck    = ~bit_cnt_q[CNT_W-1];

endmodule

// File: rtl/audio_codec_if.sv
// Left-justified 16-bit codec interface: MCLK/BCLK/LRCK generation, DAC serializer, ADC deserializer.
module audio_codec_if
    import audio_codec_if_pkg::*;
#(
    parameter int BCLK_HALF = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] dac_left,
    input  logic [SAMPLE_W-1:0] dac_right,
    output logic                dac_req,
    output logic [SAMPLE_W-1:0] adc_left,
    output logic [SAMPLE_W-1:0] adc_right,
    output logic                adc_valid,
    output logic                aud_mclk,
    output logic                aud_bclk,
    output logic                aud_lrck,
    output logic                aud_dacdat,
    input  logic                aud_adcdat
);

    logic [CNT_W-1:0]      bit_cnt;
    logic                  bclk_rise;
    logic                  bclk_fall;

    logic [MCLK_CNT_W-1:0] mclk_cnt_q;
    logic                  mclk_q;

    logic [SAMPLE_W-1:0]   shadow_l_q, shadow_l_d;
    logic [SAMPLE_W-1:0]   shadow_r_q, shadow_r_d;
    logic [SAMPLE_W-1:0]   sreg_l_q, sreg_l_d;
    logic [SAMPLE_W-1:0]   sreg_r_q, sreg_r_d;
    logic [SAMPLE_W-1:0]   tx_word;
    logic [CNT_W-1:0]      next_slot;
    logic                  frame_wrap;
    logic                  dacdat_q, dacdat_d;
    logic                  rx_done;
    logic                  xfer_pending_q;

    audio_clk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_clk_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .bclk    (aud_bclk),
        .lrck    (aud_lrck),
        .bit_cnt (bit_cnt),
        .rise    (bclk_rise),
        .fall    (bclk_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mclk_cnt_q <= '0;
            mclk_q     <= 1'b0;
        end else if (mclk_cnt_q == MCLK_CNT_W'(MCLK_HALF - 1)) begin
            mclk_cnt_q <= '0;
            mclk_q     <= ~mclk_q;
        end else begin
            mclk_cnt_q <= mclk_cnt_q + MCLK_CNT_W'(1);
        end
    end

    // The word for slot 0 is taken straight from the freshly captured inputs,
    // so the shadow update and the first data bit share one edge.
    always_comb begin
        next_slot  = bit_cnt + CNT_W'(1);
        frame_wrap = bclk_fall && (bit_cnt == CNT_W'(LAST_SLOT));
        shadow_l_d = frame_wrap ? dac_left  : shadow_l_q;
        shadow_r_d = frame_wrap ? dac_right : shadow_r_q;
        tx_word    = next_slot[CNT_W-1] ? shadow_r_d : shadow_l_d;
        dacdat_d   = dacdat_q;
        if (bclk_fall) begin
            dacdat_d = slot_active(next_slot) ? tx_word[slot_bit_index(next_slot)] : 1'b0;
        end

        sreg_l_d = sreg_l_q;
        sreg_r_d = sreg_r_q;
        if (bclk_rise && slot_active(bit_cnt)) begin
            if (bit_cnt[CNT_W-1]) begin
                sreg_r_d = {sreg_r_q[SAMPLE_W-2:0], aud_adcdat};
            end else begin
                sreg_l_d = {sreg_l_q[SAMPLE_W-2:0], aud_adcdat};
            end
        end
        rx_done = bclk_rise && (bit_cnt == CNT_W'(ADC_LAST_SLOT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_l_q     <= '0;
            shadow_r_q     <= '0;
            sreg_l_q       <= '0;
            sreg_r_q       <= '0;
            dacdat_q       <= 1'b0;
            dac_req        <= 1'b0;
            xfer_pending_q <= 1'b0;
            adc_valid      <= 1'b0;
            adc_left       <= '0;
            adc_right      <= '0;
        end else if (!enable) begin
            sreg_l_q       <= '0;
            sreg_r_q       <= '0;
            dacdat_q       <= 1'b0;
            dac_req        <= 1'b0;
            xfer_pending_q <= 1'b0;
            adc_valid      <= 1'b0;
        end else begin
            shadow_l_q     <= shadow_l_d;
            shadow_r_q     <= shadow_r_d;
            sreg_l_q       <= sreg_l_d;
            sreg_r_q       <= sreg_r_d;
            dacdat_q       <= dacdat_d;
            dac_req        <= frame_wrap;
            xfer_pending_q <= rx_done;
            adc_valid      <= xfer_pending_q;
            if (xfer_pending_q) begin
                adc_left  <= sreg_l_q;
                adc_right <= sreg_r_q;
            end
        end
    end

    assign aud_mclk   = mclk_q;
    assign aud_dacdat = dacdat_q;

endmodule

// File: tb/tb_audio_codec_if.sv
// Randomized self-checking bench for audio_codec_if against a slot-arithmetic reference model.
module tb_audio_codec_if;

    localparam int H = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        enable2;
    logic [15:0] dac_left;
    logic [15:0] dac_right;
    logic        dac_req;
    logic [15:0] adc_left;
    logic [15:0] adc_right;
    logic        adc_valid;
    logic        aud_mclk;
    logic        aud_bclk;
    logic        aud_lrck;
    logic        aud_dacdat;
    logic        aud_adcdat;

    logic        dac_req2;
    logic [15:0] adc_left2;
    logic [15:0] adc_right2;
    logic        adc_valid2;
    logic        aud_mclk2;
    logic        aud_bclk2;
    logic        aud_lrck2;
    logic        aud_dacdat2;
    logic        aud_adcdat2 = 1'b0;

    always #5 clk = ~clk;

    audio_codec_if #(.BCLK_HALF(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dac_left   (dac_left),
        .dac_right  (dac_right),
        .dac_req    (dac_req),
        .adc_left   (adc_left),
        .adc_right  (adc_right),
        .adc_valid  (adc_valid),
        .aud_mclk   (aud_mclk),
        .aud_bclk   (aud_bclk),
        .aud_lrck   (aud_lrck),
        .aud_dacdat (aud_dacdat),
        .aud_adcdat (aud_adcdat)
    );

    audio_codec_if #(.BCLK_HALF(2)) dut_fast (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable2),
        .dac_left   (dac_left),
        .dac_right  (dac_right),
        .dac_req    (dac_req2),
        .adc_left   (adc_left2),
        .adc_right  (adc_right2),
        .adc_valid  (adc_valid2),
        .aud_mclk   (aud_mclk2),
        .aud_bclk   (aud_bclk2),
        .aud_lrck   (aud_lrck2),
        .aud_dacdat (aud_dacdat2),
        .aud_adcdat (aud_adcdat2)
    );

    int nvec = 0;
    int nmis = 0;
    int k = -1;
    int m = 0;
    int cyc = 0;
    int k2 = -1;
    int n_req2 = 0;
    int n_val2 = 0;
    int last_req2 = 0;
    logic chg_next = 1'b0;
    logic [15:0] dac_fl [0:7];
    logic [15:0] dac_fr [0:7];
    logic [15:0] adc_wl [0:7];
    logic [15:0] adc_wr [0:7];
    logic [15:0] exp_al = '0;
    logic [15:0] exp_ar = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", tag, got, exp, k, $time);
        end
    endtask

    // One clk cycle: advance the model by the edge, compare, then drive new inputs.
    task automatic step();
        logic [15:0] sl, sr, w;
        logic        en_s, rst_s, en2_s;
        logic        e_bclk, e_lrck, e_dat, e_req, e_val;
        int          falls, slot, f, fr;
        sl = dac_left;
        sr = dac_right;
        en_s = enable;
        rst_s = reset;
        en2_s = enable2;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            k = -1;
            m = 0;
            exp_al = '0;
            exp_ar = '0;
        end else begin
            m++;
            k = en_s ? k + 1 : -1;
        end
        e_bclk = 1'b0; e_lrck = 1'b0; e_dat = 1'b0; e_req = 1'b0; e_val = 1'b0;
        if (k >= 0) begin
            falls  = k / (2 * H);
            slot   = (63 + falls) % 64;
            e_bclk = ((k / H) % 2) == 1;
            e_lrck = slot < 32;
            if (k > 0 && k % (2 * H) == 0 && falls % 64 == 1) begin
                e_req = 1'b1;
                dac_fl[3'((falls - 1) / 64)] = sl;
                dac_fr[3'((falls - 1) / 64)] = sr;
            end
            if (falls >= 1 && slot % 32 < 16) begin
                f = (falls - 1) / 64;
                w = (slot < 32) ? dac_fl[3'(f)] : dac_fr[3'(f)];
                e_dat = w[4'(15 - slot % 32)];
            end
            if (k >= 1 && (k - 1) % (2 * H) == H && ((k - 1) / (2 * H)) % 64 == 48) begin
                e_val = 1'b1;
                fr = ((k - 1) / (2 * H) - 1) / 64;
                exp_al = adc_wl[3'(fr)];
                exp_ar = adc_wr[3'(fr)];
            end
        end
        chk("bclk", aud_bclk, e_bclk);
        chk("lrck", aud_lrck, e_lrck);
        chk("dacdat", aud_dacdat, e_dat);
        chk("dac_req", dac_req, e_req);
        chk("adc_valid", adc_valid, e_val);
        chk("adc_left", adc_left, exp_al);
        chk("adc_right", adc_right, exp_ar);
        chk("mclk", aud_mclk, (m / 2) % 2);

        if (rst_s || !en2_s) k2 = -1; else k2++;
        if (dac_req2) begin
            n_req2++;
            if (n_req2 > 1) chk("req2_period", cyc - last_req2, 256);
            last_req2 = cyc;
        end
        if (adc_valid2) n_val2++;

        if (chg_next || (k > 2 * H && $urandom_range(0, 1499) == 0)) begin
            dac_left  = 16'($urandom);
            dac_right = 16'($urandom);
        end
        chg_next = e_req;
        aud_adcdat = 1'($urandom);
        if (k >= 0) begin
            falls = k / (2 * H);
            slot  = (63 + falls) % 64;
            if (falls >= 1 && slot % 32 < 16) begin
                f = (falls - 1) / 64;
                w = (slot < 32) ? adc_wl[3'(f)] : adc_wr[3'(f)];
                aud_adcdat = w[4'(15 - slot % 32)];
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        enable2 = 1'b0;
        dac_left = 16'hA5C3;
        dac_right = 16'h0F0F;
        aud_adcdat = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (6) step();

        adc_wl[0] = 16'h8001;
        adc_wr[0] = 16'h7FFE;
        for (int i = 1; i < 8; i++) begin
            adc_wl[i] = 16'($urandom);
            adc_wr[i] = 16'($urandom);
        end
        enable = 1'b1;
        enable2 = 1'b1;
        // Run three full frames and stop partway through the fourth at slot 40.
        for (int i = 0; i < 20000 && !(k >= 0 && k / (2 * H) == 233); i++) begin
            step();
            if (k2 == 712) enable2 = 1'b0;
        end
        enable = 1'b0;
        repeat (20) step();

        for (int i = 0; i < 8; i++) begin
            adc_wl[i] = 16'($urandom);
            adc_wr[i] = 16'($urandom);
        end
        enable = 1'b1;
        for (int i = 0; i < 3000 && k < 1700; i++) step();

        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        enable = 1'b0;
        repeat (4) step();

        chk("req2_count", n_req2, 3);
        chk("val2_count", n_val2, 3);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/audio_codec_if.md
AUDIO_CODEC_IF -- requirements
Module: audio_codec_if

Interface
REQ-001 BCLK_HALF, 16, clk cycles per BCLK half-period; legal range 2..255.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  codec configuration complete; the block runs only while this is high.
REQ-005 dac_left, dac_right  input  16 each  signed samples for playback.
REQ-006 dac_req  output  1  one-cycle pulse when dac_left/dac_right are captured.
REQ-007 adc_left, adc_right  output  16 each  recorded samples.
REQ-008 adc_valid  output  1  one-cycle pulse when adc_left/adc_right update.
REQ-009 aud_mclk  output  1  codec master clock.
REQ-010 aud_bclk  output  1  codec bit clock.
REQ-011 aud_lrck  output  1  shared DAC/ADC LR clock.
REQ-012 aud_dacdat  output  1  serial playback data.
REQ-013 aud_adcdat  input  1  serial record data.

Function
REQ-014 aud_mclk SHALL be clk/4 (toggle every 2 clk), free-running whenever reset is low, and independent of enable.
REQ-015 A divider counter div_cnt SHALL count 0..BCLK_HALF-1 and wrap; aud_bclk SHALL toggle in the cycle where div_cnt==BCLK_HALF-1.
REQ-016 A 6-bit bit_cnt SHALL advance, modulo 64, on each BCLK falling toggle; each frame is 64 BCLK periods with 32 per channel.
REQ-017 aud_lrck SHALL be ~bit_cnt[5]: high for slots 0..31 (left channel), low for slots 32..63 (right channel).
REQ-018 The format SHALL be left-justified, 16-bit, MSB first: the MSB starts in slot 0 (left) or slot 32 (right), and no delay slot is inserted.
REQ-019 aud_dacdat SHALL change only on BCLK falling toggles.
REQ-020 In slot s with s mod 32 < 16, aud_dacdat SHALL be the channel shadow bit [15-(s mod 32)]; in every other slot it SHALL be 0.
REQ-021 On the falling toggle that wraps bit_cnt from 63 to 0, dac_left/dac_right SHALL be copied into the shadow registers and dac_req SHALL pulse in that same cycle; input changes after that cycle do not affect the current frame.
REQ-022 aud_adcdat SHALL be sampled on each BCLK rising toggle in slots with s mod 32 < 16 and shifted MSB first into the left or right shift register.
REQ-023 On the rising toggle of slot 47 (last right-channel bit), both shift registers SHALL transfer to adc_left/adc_right on the next clk, with adc_valid pulsing in that same cycle.
REQ-024 adc_left/adc_right SHALL hold their value between adc_valid pulses.
REQ-025 Idle state, entered while enable is low: div_cnt=0, bit_cnt=63, aud_bclk=0, aud_lrck=0, aud_dacdat=0, dac_req=0, adc_valid=0; adc_left/adc_right are retained.
REQ-026 When enable is first sampled high, the first BCLK rising toggle SHALL occur BCLK_HALF cycles later and the first falling toggle 2*BCLK_HALF cycles later; the falling toggle enters slot 0 and raises lrck and dac_req.
REQ-027 If enable deasserts mid-frame, the block SHALL enter Idle on the next clk and drop the partial frame: no adc_valid, and the shift registers clear.
REQ-028 The block SHALL operate continuously with no gaps between frames; dac_req and adc_valid SHALL each pulse exactly once per frame.

Reset
REQ-029 Reset SHALL force the Idle values, set aud_mclk=0, clear the mclk divider, and set adc_left=adc_right=0 and the shadow/shift registers to 0.
REQ-030 Reset SHALL take priority over enable in the same cycle.

Structure
REQ-031 A shared package SHALL hold SAMPLE_W=16, SLOT_BITS=32, FRAME_BITS=64, and the MCLK divide constant 4.
REQ-032 The BCLK/LRCK timing generator SHALL be one sub-module, audio_clk_gen, outputting bclk, lrck, bit_cnt, and single-cycle rise/fall strobes; the serializer and deserializer stay in the top level.

Verification
REQ-033 Reset high for 3 clk, then enable=1 with BCLK_HALF=16: first bclk rise at cycle 16, first fall plus dac_req plus lrck=1 at cycle 32, aud_mclk period 4 clk throughout.
REQ-034 dac_left=16'hA5C3, dac_right=16'h0F0F: aud_dacdat shows A5C3 MSB-first in slots 0..15, 0 in slots 16..31, 0F0F in slots 32..47, and 0 in slots 48..63.
REQ-035 Behavioural codec model drives aud_adcdat 16'h8001 (left) and 16'h7FFE (right) on falling edges: adc_valid pulses once per frame one clk after the slot-47 rise, with adc_left=8001 and adc_right=7FFE.
REQ-036 dac_left is changed in the cycle after dac_req: the current frame still serializes the old value and the next frame serializes the new value.
REQ-037 enable drops at slot 40: Idle next clk, no adc_valid, prior adc values retained; after re-enable, timing repeats per REQ-033.
REQ-038 BCLK_HALF=2 over 3 frames: frame period is 256 clk, and exactly 3 dac_req and 3 adc_valid pulses occur.
